// File: rtl/fixed_softmax_normalizer_if.sv
// Stream bundle for the softmax back end: exp lanes in,
// normalised lanes out, each with a valid/ready handshake.
interface fixed_softmax_normalizer_if #(
  parameter int P     = 1,
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
);
  logic [P-1:0][IN_W-1:0]  data_in_0;
  logic                    data_in_0_valid;
  logic                    data_in_0_ready;
  logic [P-1:0][OUT_W-1:0] data_out_0;
  logic                    data_out_0_valid;
  logic                    data_out_0_ready;

  modport master (
    output data_in_0,
    output data_in_0_valid,
    input  data_in_0_ready,
    input  data_out_0,
    input  data_out_0_valid,
    output data_out_0_ready
  );

  modport slave (
    input  data_in_0,
    input  data_in_0_valid,
    output data_in_0_ready,
    output data_out_0,
    output data_out_0_valid,
    input  data_out_0_ready
  );
endinterface

// File: rtl/fixed_softmax_normalizer.sv
// Softmax back end: buffers one exp vector, divides 2^R by its sum,
// then streams exp_i * (1/sum) out at the input parallelism.
module fixed_softmax_normalizer #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 7,
  parameter int RECIP_WIDTH                 = 16
) (
  input logic clk,
  input logic rst,
  fixed_softmax_normalizer_if.slave io
);
  localparam int IN_W     = DATA_IN_0_PRECISION_0;
  localparam int N        = DATA_IN_0_TENSOR_SIZE_DIM_0;
  localparam int P        = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int OUT_W    = DATA_OUT_0_PRECISION_0;
  localparam int OUT_FRAC = DATA_OUT_0_PRECISION_1;
  localparam int R        = RECIP_WIDTH;
  localparam int DEPTH    = N / P;
  localparam int SUM_W    = IN_W + $clog2(N);
  localparam int CW       = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int DCW      = $clog2(R + 1);
  localparam int SHIFT    = R - OUT_FRAC;
  localparam int PW       = IN_W + R;

  // The input fraction cancels in exp/sum, so it only bounds the config.
  if (DATA_IN_0_PRECISION_1 > IN_W || OUT_W < OUT_FRAC + 1 ||
      R < OUT_FRAC || N % P != 0) begin : g_bad_cfg
    $error("fixed_softmax_normalizer: inconsistent parameters");
  end

  typedef logic [P-1:0][IN_W-1:0]  beat_in_t;
  typedef logic [P-1:0][OUT_W-1:0] beat_out_t;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_RECIP,
    S_LOAD,
    S_EMIT
  } state_t;

  state_t state_q, state_d;

  beat_in_t buf_mem [DEPTH];

  logic [CW-1:0]    wr_cnt, rd_cnt, rd_nx;
  logic [SUM_W-1:0] sum_q, beat_sum;
  logic [DCW-1:0]   div_cnt;
  logic [SUM_W-1:0] rem_q, rem_nx;
  logic [SUM_W:0]   rem_sh;
  logic [R-1:0]     quo_q, rq_q;
  logic [R:0]       quo_nx;
  logic             ge;
  beat_out_t        dout_q;
  logic             valid_q, ready_q;

  logic st_collect, st_recip, st_load, st_emit;
  logic wr_last, rd_last, div_last, sum_zero;
  logic in_fire, out_fire, div_step, div_skip, load;

  function automatic beat_out_t scale(input beat_in_t b,
                                      input logic [R-1:0] q);
    logic [PW-1:0] prod, shr;
    beat_out_t     o;
    o = '0;
    for (int l = 0; l < P; l++) begin
      prod = PW'(b[l]) * PW'(q);
      shr  = prod >> SHIFT;
      if (|(shr >> OUT_W)) o[l] = '1;
      else                 o[l] = shr[OUT_W-1:0];
    end
    return o;
  endfunction

  assign st_collect = state_q == S_COLLECT;
  assign st_recip   = state_q == S_RECIP;
  assign st_load    = state_q == S_LOAD;
  assign st_emit    = state_q == S_EMIT;

  assign wr_last  = wr_cnt == CW'(DEPTH - 1);
  assign rd_last  = rd_cnt == CW'(DEPTH - 1);
  assign rd_nx    = rd_cnt + 1'b1;
  assign div_last = div_cnt == DCW'(R);
  assign sum_zero = sum_q == '0;

  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < P; l++)
      beat_sum = beat_sum + SUM_W'(io.data_in_0[l]);
  end

  // Restoring step; the dividend 2^R feeds a single 1 on the first step.
  always_comb begin
    rem_sh = {rem_q, div_cnt == '0};
    ge     = rem_sh >= {1'b0, sum_q};
    rem_nx = SUM_W'(ge ? rem_sh - {1'b0, sum_q} : rem_sh);
    quo_nx = {quo_q, ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COLLECT: if (in_fire && wr_last) state_d = S_RECIP;
      S_RECIP:   if (sum_zero || div_last) state_d = S_LOAD;
      S_LOAD:    state_d = S_EMIT;
      S_EMIT:    if (out_fire && rd_last) state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    in_fire  = 1'b0;
    out_fire = 1'b0;
    div_step = 1'b0;
    div_skip = 1'b0;
    load     = 1'b0;
    unique case (1'b1)
      st_collect: in_fire = io.data_in_0_valid & ready_q;
      st_recip: begin
        div_step = !sum_zero;
        div_skip = sum_zero;
      end
      st_load:    load = 1'b1;
      st_emit:    out_fire = valid_q & io.data_out_0_ready;
      default: ;
    endcase
  end

  assign io.data_in_0_ready  = ready_q;
  assign io.data_out_0_valid = valid_q;
  assign io.data_out_0       = dout_q;

  always_ff @(posedge clk) begin
    if (in_fire) buf_mem[wr_cnt] <= io.data_in_0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      sum_q   <= '0;
      div_cnt <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rq_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= state_d == S_COLLECT;
      if (in_fire) begin
        sum_q  <= sum_q + beat_sum;
        wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
        if (wr_last) begin
          div_cnt <= '0;
          rem_q   <= '0;
          quo_q   <= '0;
        end
      end
      if (div_step) begin
        div_cnt <= div_cnt + 1'b1;
        rem_q   <= rem_nx;
        quo_q   <= quo_nx[R-1:0];
        // Only sum==1 yields 2^R, which does not fit in R bits.
        if (div_last) rq_q <= quo_nx[R] ? '1 : quo_nx[R-1:0];
      end
      if (div_skip) rq_q <= '0;
      if (load) begin
        dout_q  <= scale(buf_mem[0], rq_q);
        valid_q <= 1'b1;
        rd_cnt  <= '0;
      end
      if (out_fire) begin
        if (rd_last) begin
          valid_q <= 1'b0;
          rd_cnt  <= '0;
          sum_q   <= '0;
        end else begin
          rd_cnt <= rd_nx;
          dout_q <= scale(buf_mem[rd_nx], rq_q);
        end
      end
    end
  end
endmodule

// File: tb/tb_fixed_softmax_normalizer.sv
// Scoreboard bench for fixed_softmax_normalizer: directed vectors on
// a 4x1 and a 4x2 instance, checked by an independent monitor.
`timescale 1ns/1ps
module tb_fixed_softmax_normalizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_softmax_normalizer_if #(.P(1), .IN_W(8), .OUT_W(8)) ifa ();
  fixed_softmax_normalizer_if #(.P(2), .IN_W(8), .OUT_W(8)) ifb ();

  fixed_softmax_normalizer #(
    .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(4),
    .DATA_IN_0_TENSOR_SIZE_DIM_0(4), .DATA_IN_0_PARALLELISM_DIM_0(1),
    .DATA_OUT_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_1(7),
    .RECIP_WIDTH(16)
  ) ua (.clk(clk), .rst(rst), .io(ifa));

  fixed_softmax_normalizer #(
    .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(4),
    .DATA_IN_0_TENSOR_SIZE_DIM_0(4), .DATA_IN_0_PARALLELISM_DIM_0(2),
    .DATA_OUT_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_1(7),
    .RECIP_WIDTH(16)
  ) ub (.clk(clk), .rst(rst), .io(ifb));

  int exp_a [$];
  int exp_b [$];

  // written by the stimulus process only
  int hs_a = 0, lat_a = 0, hs_b = 0, lat_b = 0;
  bit done = 0;

  // written by the monitor process only
  int checks = 0, fails = 0;
  int acc_a = 0, beat_a = 0, beat_b = 0;
  bit pv_a = 0, pv_b = 0, rchk_a = 0, rchk_b = 0;
  bit rst_seen = 1, fin = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", int'(ifa.data_in_0_ready), 0);
      chk("rst_valid", int'(ifa.data_out_0_valid), 0);
      chk("rst_data", int'(ifa.data_out_0), 0);
      beat_a = 0; beat_b = 0;
      pv_a = 0; pv_b = 0;
      rchk_a = 0; rchk_b = 0;
    end else begin
      if (rst_seen) chk("rel_ready", int'(ifa.data_in_0_ready), 1);
      if (rchk_a) chk("ret_ready_a", int'(ifa.data_in_0_ready), 1);
      if (rchk_b) chk("ret_ready_b", int'(ifb.data_in_0_ready), 1);
      rchk_a = 0; rchk_b = 0;

      if (ifa.data_out_0_valid && !pv_a) chk("lat_a", cyc - hs_a, lat_a);
      pv_a = ifa.data_out_0_valid;
      if (ifa.data_out_0_valid) begin
        chk("emit_ready_a", int'(ifa.data_in_0_ready), 0);
        if (exp_a.size() == 0) chk("extra_a", int'(ifa.data_out_0_valid), 0);
        else if (ifa.data_out_0_ready) begin
          chk("out_a", int'(ifa.data_out_0), exp_a.pop_front());
          acc_a++; beat_a++;
          if (beat_a == 4) begin beat_a = 0; rchk_a = 1; end
        end else chk("hold_a", int'(ifa.data_out_0), exp_a[0]);
      end

      if (ifb.data_out_0_valid && !pv_b) chk("lat_b", cyc - hs_b, lat_b);
      pv_b = ifb.data_out_0_valid;
      if (ifb.data_out_0_valid) begin
        if (exp_b.size() == 0) chk("extra_b", int'(ifb.data_out_0_valid), 0);
        else if (ifb.data_out_0_ready) begin
          chk("out_b", int'(ifb.data_out_0), exp_b.pop_front());
          beat_b++;
          if (beat_b == 2) begin beat_b = 0; rchk_b = 1; end
        end else chk("hold_b", int'(ifb.data_out_0), exp_b[0]);
      end

      if (done && !fin) begin
        chk("left_a", exp_a.size(), 0);
        chk("left_b", exp_b.size(), 0);
        fin = 1;
      end
    end
    rst_seen = rst;
  end

  task automatic send_a(input logic [7:0] v);
    int n = 0;
    ifa.data_in_0 = v;
    ifa.data_in_0_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ifa.data_in_0_ready) break;
      n++;
      if (n > 200) begin
        $display("FAIL send_a: ready low for %0d cycles, required high", n);
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    hs_a = cyc;
    ifa.data_in_0_valid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] v);
    int n = 0;
    ifb.data_in_0 = v;
    ifb.data_in_0_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ifb.data_in_0_ready) break;
      n++;
      if (n > 200) begin
        $display("FAIL send_b: ready low for %0d cycles, required high", n);
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    hs_b = cyc;
    ifb.data_in_0_valid = 1'b0;
  endtask

  task automatic vec_a(input int v [4], input int e [4], input int lat);
    for (int i = 0; i < 4; i++) exp_a.push_back(e[i]);
    lat_a = lat;
    for (int i = 0; i < 4; i++) send_a(8'(v[i]));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_a.size() != 0 || exp_b.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > 400) begin
        $display("FAIL drain: %0d/%0d beats outstanding, required 0",
                 exp_a.size(), exp_b.size());
        $fatal(1);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, n;
    ifa.data_in_0 = '0; ifa.data_in_0_valid = 1'b0; ifa.data_out_0_ready = 1'b1;
    ifb.data_in_0 = '0; ifb.data_in_0_valid = 1'b0; ifb.data_out_0_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // uniform vector: 0.25 each
    vec_a('{16, 16, 16, 16}, '{32, 32, 32, 32}, 18);
    drain();
    // one-hot
    vec_a('{16, 0, 0, 0}, '{128, 0, 0, 0}, 18);
    drain();
    // zero sum skips the divide
    vec_a('{0, 0, 0, 0}, '{0, 0, 0, 0}, 2);
    drain();
    // sum 1: reciprocal clamps to 65535
    vec_a('{1, 0, 0, 0}, '{127, 0, 0, 0}, 18);
    drain();
    // max inputs: Rq 64, floor(255*64/512) = 31
    vec_a('{255, 255, 255, 255}, '{31, 31, 31, 31}, 18);
    drain();

    // backpressure on output beat 1
    base = acc_a;
    vec_a('{16, 16, 16, 16}, '{32, 32, 32, 32}, 18);
    n = 0;
    while (acc_a < base + 1) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        $display("FAIL stall_wait: accepted %0d, required %0d", acc_a - base, 1);
        $fatal(1);
      end
    end
    ifa.data_out_0_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 ifa.data_out_0_ready = 1'b1;
    drain();

    // reset mid-vector discards the partial sum and buffer
    send_a(8'd100);
    send_a(8'd100);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    vec_a('{16, 16, 16, 16}, '{32, 32, 32, 32}, 18);
    drain();

    // two lanes: {48,16},{0,0} -> {96,32},{0,0}
    exp_b.push_back(int'({8'd32, 8'd96}));
    exp_b.push_back(0);
    lat_b = 18;
    send_b({8'd16, 8'd48});
    send_b(16'd0);
    drain();

    done = 1;
    n = 0;
    while (!fin) begin
      @(posedge clk);
      n++;
      if (n > 20) begin
        $display("FAIL final_check: monitor did not finish, required finish");
        $fatal(1);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
